// File: rtl/capture_pkg.sv
// Shared types and defaults for the OV7670 capture front end.
package capture_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_ADDR_W = 19;

  typedef logic [15:0] rgb565_t;

  // The camera sends the high byte of each pixel first.
  function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/capture_edge_det.sv
// Registers one level signal and reports its rising and falling edges.
module capture_edge_det (
  input  logic pclk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic prev_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;
  assign fall = ~d & prev_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream to RGB565 frame-buffer writer with line/frame checks.
// Define CAPTURE_DECIMATE_EN to keep only even-x/even-y pixels with a compact address range.
module ov7670_capture
  import capture_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        din,
  output logic [15:0]       pixel,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0] WIDTH_X  = XW'(WIDTH);
  localparam logic [YW-1:0] HEIGHT_Y = YW'(HEIGHT);

  logic       vsync_q;
  logic       href_q;
  logic [7:0] din_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      din_q   <= 8'h00;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      din_q   <= din;
    end
  end

  logic vs_rise, vs_fall, hs_rise, hs_fall;

  capture_edge_det u_vsync_edge (
    .pclk (pclk),
    .rst  (rst),
    .d    (vsync_q),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  capture_edge_det u_href_edge (
    .pclk (pclk),
    .rst  (rst),
    .d    (href_q),
    .rise (hs_rise),
    .fall (hs_fall)
  );

  state_e            state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic              phase_q;
  logic              err_q;
  logic [7:0]        hi_q;
  rgb565_t           pixel_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              done_q;
  logic              ferr_q;

  logic          phase_d;
  logic          in_range;
  logic          keep;
  logic          line_err;
  logic [YW-1:0] y_d;
  logic [YW-1:0] y_end;
  logic          end_err;

  always_comb begin
    // A fresh line always begins on the high byte.
    phase_d  = hs_rise ? 1'b0 : phase_q;
    in_range = (x_q < WIDTH_X) && (y_q < HEIGHT_Y);
`ifdef CAPTURE_DECIMATE_EN
    keep     = in_range & ~x_q[0] & ~y_q[0];
`else
    keep     = in_range;
`endif
    line_err = (x_q != WIDTH_X) | phase_q;
    y_d      = (y_q == HEIGHT_Y) ? y_q : y_q + 1'b1;
    y_end    = hs_fall ? y_d : y_q;
    // Line-end check folds in before the frame check; href still high means an aborted line.
    end_err  = err_q | (hs_fall & line_err) | href_q | (y_end != HEIGHT_Y);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      phase_q <= 1'b0;
      err_q   <= 1'b0;
      hi_q    <= 8'h00;
      pixel_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (we_q) begin
        addr_q <= addr_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (vs_fall) begin
            state_q <= ST_ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (vs_rise) begin
            done_q  <= 1'b1;
            ferr_q  <= end_err;
            state_q <= ST_IDLE;
          end else if (hs_fall) begin
            if (line_err) begin
              err_q <= 1'b1;
            end
            x_q     <= '0;
            phase_q <= 1'b0;
            y_q     <= y_d;
          end else if (href_q) begin
            phase_q <= ~phase_d;
            if (!phase_d) begin
              hi_q <= din_q;
            end else if (in_range) begin
              x_q <= x_q + 1'b1;
              if (keep) begin
                we_q    <= 1'b1;
                pixel_q <= pack_rgb565(hi_q, din_q);
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pixel      = pixel_q;
  assign addr       = addr_q;
  assign we         = we_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized frame stimulus checked against a per-frame scoreboard model of ov7670_capture.
module tb_ov7670_capture;

  localparam int W  = 4;
`ifdef CAPTURE_DECIMATE_EN
  localparam int H  = 4;
`else
  localparam int H  = 2;
`endif
  localparam int AW = 5;

  logic          pclk = 1'b0;
  logic          rst;
  logic          vsync;
  logic          href;
  logic [7:0]    din;
  logic [15:0]   pixel;
  logic [AW-1:0] addr;
  logic          we;
  logic          frame_done;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  int frames = 0;

  typedef struct {
    logic [15:0] px;
    int          a;
  } wr_t;

  wr_t  exp_wr[$];
  bit   exp_fe[$];
  int   len_a[8];
  wr_t  mon_w;
  bit   mon_fe;
  logic we_prev = 1'b0;

  ov7670_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync      (vsync),
    .href       (href),
    .din        (din),
    .pixel      (pixel),
    .addr       (addr),
    .we         (we),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic v, input logic h, input logic [7:0] d);
    vsync = v;
    href  = h;
    din   = d;
    @(posedge pclk);
    #1;
  endtask

  function automatic bit keep_px(input int p, input int l);
`ifdef CAPTURE_DECIMATE_EN
    return (p % 2 == 0) && (l % 2 == 0);
`else
    return 1'b1;
`endif
  endfunction

  // Scoreboard: every write and every frame end must match the model's queues in order.
  always @(negedge pclk) begin
    if (we) begin
      check_eq("we_gap", 32'(we_prev), 32'd0);
      if (exp_wr.size() == 0) begin
        check_eq("unexp_we", 32'(we), 32'd0);
      end else begin
        mon_w = exp_wr.pop_front();
        check_eq("pixel", 32'(pixel), 32'(mon_w.px));
        check_eq("addr", 32'(addr), 32'(mon_w.a));
      end
    end
    if (frame_done) begin
      if (exp_fe.size() == 0) begin
        check_eq("unexp_done", 32'(frame_done), 32'd0);
      end else begin
        mon_fe = exp_fe.pop_front();
        check_eq("frame_err", 32'(frame_err), 32'(mon_fe));
        $display("frame %0d done err=%0b", frames, frame_err);
        frames++;
      end
    end else if (frame_err) begin
      check_eq("err_wo_done", 32'(frame_err), 32'd0);
    end
    we_prev = we;
  end

  // One bracketed frame; line byte counts come from len_a.
  task automatic run_frame(input int nlines, input bit abort_last, input bit tight_end,
                           input bit first_ab);
    int          a;
    bit          err;
    int          n;
    logic [7:0]  b[$];
    wr_t         w;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'h00);
    a   = 0;
    err = (nlines != H) || abort_last;
    for (int l = 0; l < nlines; l++) begin
      n = len_a[l];
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom_range(0, 255)));
      if (first_ab && l == 0 && n >= 2) begin
        b[0] = 8'hAB;
        b[1] = 8'hCD;
      end
      if ((n % 2) != 0 || (n / 2) != W) err = 1'b1;
      for (int p = 0; p < n / 2; p++) begin
        if (l < H && p < W) begin
          if (keep_px(p, l)) begin
            w.px = {b[2*p], b[2*p+1]};
            w.a  = a;
            exp_wr.push_back(w);
            a++;
          end
        end else begin
          err = 1'b1;
        end
      end
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, b[i]);
      if (l == nlines - 1) begin
        if (abort_last) begin
          exp_fe.push_back(err);
          for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'($urandom_range(0, 255)));
          tick(1'b1, 1'b0, 8'h00);
        end else if (tight_end) begin
          exp_fe.push_back(err);
          tick(1'b1, 1'b0, 8'h00);
        end else begin
          for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1'b0, 1'b0, 8'h00);
          exp_fe.push_back(err);
          tick(1'b1, 1'b0, 8'h00);
        end
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) tick(1'b0, 1'b0, 8'h00);
      end
    end
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic fill_clean();
    for (int l = 0; l < 8; l++) len_a[l] = 2 * W;
  endtask

  initial begin
    rst   = 1'b1;
    vsync = 1'b0;
    href  = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_pixel", 32'(pixel), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;

    // Startup mid-frame: data with no preceding vsync fall must be ignored.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 8'h00);

    // Clean frame starting with 0xAB, 0xCD.
    fill_clean();
    run_frame(H, 1'b0, 1'b0, 1'b1);

    // Over-long line (5 pixels).
    fill_clean();
    len_a[0] = 2 * W + 2;
    run_frame(H, 1'b0, 1'b0, 1'b0);

    // Odd byte count line.
    fill_clean();
    len_a[0] = 2 * W - 1;
    run_frame(H, 1'b0, 1'b0, 1'b0);

    // Reset mid-line: two pixels written, then rst while href is high.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'h00);
    mon_w.px = 16'h1234; mon_w.a = 0; exp_wr.push_back(mon_w);
    mon_w.px = 16'h5678; mon_w.a = 1; exp_wr.push_back(mon_w);
    tick(1'b0, 1'b1, 8'h12);
    tick(1'b0, 1'b1, 8'h34);
    tick(1'b0, 1'b1, 8'h56);
    tick(1'b0, 1'b1, 8'h78);
    tick(1'b0, 1'b1, 8'h9A);
    rst = 1'b1;
    tick(1'b0, 1'b1, 8'hBC);
    rst = 1'b0;
    check_eq("midrst_pixel", 32'(pixel), 32'd0);
    check_eq("midrst_addr", 32'(addr), 32'd0);
    check_eq("midrst_we", 32'(we), 32'd0);
    check_eq("midrst_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 8'hEE);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'hDD);
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00);

    // Clean frame after reset, then simultaneous line end and frame end.
    fill_clean();
    run_frame(H, 1'b0, 1'b0, 1'b0);
    run_frame(H, 1'b0, 1'b1, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      for (int l = 0; l < 8; l++) begin
        if ($urandom_range(0, 3) != 0) len_a[l] = 2 * W;
        else len_a[l] = int'($urandom_range(1, 2 * W + 3));
      end
      run_frame(int'($urandom_range(1, H + 1)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0), 1'b0);
    end

    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 8'h00);
    check_eq("wr_left", 32'(exp_wr.size()), 32'd0);
    check_eq("fe_left", 32'(exp_fe.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
